nco_bcd_cnt_disp: RTL and testbench

Parametrised successor to the fixed six-digit NCO/counter/display top. It has a programmable NCO tick period, an N-digit BCD up/down counter with enable, clear and wrap flag, and a multiplexed 7-segment scan driver. It sits between the board clock/reset and the seven-segment display pins, and exposes tick and wrap strobes for neighbouring blocks.

---
 rtl/nco_bcd_cnt_disp.sv | 155 +++++++++++++++
 tb/tb_nco_bcd_cnt_disp.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/nco_bcd_cnt_disp.sv
// NCO-driven N-digit BCD up/down counter with a multiplexed 7-segment scan driver.
// Optional leading-zero blanking: define NCO_BCD_CNT_DISP_LZB_EN.
module nco_bcd_cnt_disp #(
    parameter int DIGITS   = 6,
    parameter int NCO_W    = 32,
    parameter int SCAN_DIV = 50000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NCO_W-1:0]  i_nco_num,
    input  logic              i_en,
    input  logic              i_up,
    input  logic              i_clr,
    output logic              o_tick,
    output logic              o_wrap,
    output logic [6:0]        o_seg,
    output logic              o_seg_dp,
    output logic [DIGITS-1:0] o_seg_enb
);
    localparam int SCAN_W = $clog2(SCAN_DIV);
    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [NCO_W-1:0]  r_nco_cnt;
    logic [3:0]        r_dig [DIGITS];
    logic [SCAN_W-1:0] r_scan_cnt;
    logic [IDX_W-1:0]  r_idx;

    logic       w_term;
    logic       w_carry;
    logic [3:0] w_dig_nxt [DIGITS];
    logic [3:0] w_cur;
    logic       w_blank;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'h3F;
            4'd1:    seg_decode = 7'h06;
            4'd2:    seg_decode = 7'h5B;
            4'd3:    seg_decode = 7'h4F;
            4'd4:    seg_decode = 7'h66;
            4'd5:    seg_decode = 7'h6D;
            4'd6:    seg_decode = 7'h7D;
            4'd7:    seg_decode = 7'h07;
            4'd8:    seg_decode = 7'h7F;
            4'd9:    seg_decode = 7'h6F;
            default: seg_decode = 7'h00;
        endcase
    endfunction

    // Periods 0 and 1 both terminate every cycle; a period lowered below the phase terminates at once.
    assign w_term = (i_nco_num <= NCO_W'(1)) || (r_nco_cnt >= i_nco_num - NCO_W'(1));

    // Ripple carry/borrow through the digits; a carry out of the top digit is the wrap.
    always_comb begin
        w_carry = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            w_dig_nxt[k] = r_dig[k];
            if (w_carry) begin
                if (i_up) begin
                    if (r_dig[k] >= 4'd9) begin
                        w_dig_nxt[k] = 4'd0;
                    end else begin
                        w_dig_nxt[k] = r_dig[k] + 4'd1;
                        w_carry      = 1'b0;
                    end
                end else begin
                    if (r_dig[k] == 4'd0 || r_dig[k] > 4'd9) begin
                        w_dig_nxt[k] = 4'd9;
                    end else begin
                        w_dig_nxt[k] = r_dig[k] - 4'd1;
                        w_carry      = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_nco_cnt <= '0;
            o_tick    <= 1'b0;
            o_wrap    <= 1'b0;
            for (int k = 0; k < DIGITS; k++) r_dig[k] <= 4'd0;
        end else if (i_clr) begin
            r_nco_cnt <= '0;
            o_tick    <= 1'b0;
            o_wrap    <= 1'b0;
            for (int k = 0; k < DIGITS; k++) r_dig[k] <= 4'd0;
        end else if (!i_en) begin
            o_tick <= 1'b0;
            o_wrap <= 1'b0;
        end else if (w_term) begin
            r_nco_cnt <= '0;
            o_tick    <= 1'b1;
            o_wrap    <= w_carry;
            for (int k = 0; k < DIGITS; k++) r_dig[k] <= w_dig_nxt[k];
        end else begin
            r_nco_cnt <= r_nco_cnt + NCO_W'(1);
            o_tick    <= 1'b0;
            o_wrap    <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scan_cnt <= '0;
            r_idx      <= '0;
        end else if (r_scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
            r_scan_cnt <= '0;
            r_idx      <= (r_idx == IDX_W'(DIGITS - 1)) ? '0 : r_idx + IDX_W'(1);
        end else begin
            r_scan_cnt <= r_scan_cnt + SCAN_W'(1);
        end
    end

    always_comb begin
        w_cur = 4'd0;
        for (int k = 0; k < DIGITS; k++) begin
            if (r_idx == IDX_W'(k)) w_cur = r_dig[k];
        end
    end

`ifdef NCO_BCD_CNT_DISP_LZB_EN
    logic [DIGITS-1:0] w_hi_zero;
    logic              w_z;

    // w_hi_zero[k]: digit k and every digit above it are zero.
    always_comb begin
        w_z       = 1'b1;
        w_hi_zero = '0;
        w_blank   = 1'b0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            w_z          = w_z & (r_dig[k] == 4'd0);
            w_hi_zero[k] = w_z;
        end
        for (int k = 1; k < DIGITS; k++) begin
            if (r_idx == IDX_W'(k)) w_blank = w_hi_zero[k];
        end
    end
`else
    assign w_blank = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_seg     <= 7'h00;
            o_seg_dp  <= 1'b0;
            o_seg_enb <= '1;
        end else begin
            o_seg     <= w_blank ? 7'h00 : seg_decode(w_cur);
            o_seg_dp  <= (r_idx == '0) && !i_up;
            o_seg_enb <= ~(DIGITS'(1) << r_idx);
        end
    end
endmodule

// File: tb/tb_nco_bcd_cnt_disp.sv
// Directed bench for nco_bcd_cnt_disp: a 6-digit instance plus a 2-digit instance for the full wrap.
module tb_nco_bcd_cnt_disp;
    localparam int SD = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] i_nco_num;
    logic        i_en, i_up, i_clr;

    logic       a_tick, a_wrap, a_dp;
    logic [6:0] a_seg;
    logic [5:0] a_enb;
    logic       b_tick, b_wrap, b_dp;
    logic [6:0] b_seg;
    logic [1:0] b_enb;

    int n_cmp = 0;
    int n_err = 0;

    nco_bcd_cnt_disp #(.DIGITS(6), .NCO_W(32), .SCAN_DIV(SD)) u_dut (
        .clk(clk), .rst_n(rst_n), .i_nco_num(i_nco_num), .i_en(i_en), .i_up(i_up),
        .i_clr(i_clr), .o_tick(a_tick), .o_wrap(a_wrap), .o_seg(a_seg),
        .o_seg_dp(a_dp), .o_seg_enb(a_enb)
    );

    nco_bcd_cnt_disp #(.DIGITS(2), .NCO_W(32), .SCAN_DIV(SD)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .i_nco_num(i_nco_num), .i_en(i_en), .i_up(i_up),
        .i_clr(i_clr), .o_tick(b_tick), .o_wrap(b_wrap), .o_seg(b_seg),
        .o_seg_dp(b_dp), .o_seg_enb(b_enb)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [3:0] seg2dig(input logic [6:0] s);
        case (s)
            7'h3F, 7'h00: seg2dig = 4'd0;
            7'h06: seg2dig = 4'd1;
            7'h5B: seg2dig = 4'd2;
            7'h4F: seg2dig = 4'd3;
            7'h66: seg2dig = 4'd4;
            7'h6D: seg2dig = 4'd5;
            7'h7D: seg2dig = 4'd6;
            7'h07: seg2dig = 4'd7;
            7'h7F: seg2dig = 4'd8;
            7'h6F: seg2dig = 4'd9;
            default: seg2dig = 4'hF;
        endcase
    endfunction

    // Reconstruct the displayed BCD value over two full scan rounds; unseen digits stay F.
    task automatic read_val(input bit second, output logic [23:0] v);
        logic [5:0] e;
        logic [6:0] s;
        int nd;
        nd = second ? 2 : 6;
        v  = '0;
        for (int p = 0; p < nd; p++) v[p*4 +: 4] = 4'hF;
        for (int c = 0; c < 2 * 6 * SD; c++) begin
            @(negedge clk);
            e = second ? {4'b1111, b_enb} : a_enb;
            s = second ? b_seg : a_seg;
            for (int p = 0; p < nd; p++) begin
                if (e == ~(6'd1 << p)) v[p*4 +: 4] = seg2dig(s);
            end
        end
    endtask

    task automatic wait_tick(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!a_tick && n < 64);
    endtask

    initial begin
        int n, ticks, bticks, wraps, wrap_at, errs, dp_hi, p0, pos;
        logic [23:0] v;
        logic [5:0]  prev;
        logic [6:0]  exp_seg;

        rst_n     = 1'b0;
        i_nco_num = $urandom;
        i_en      = 1'($urandom_range(0, 1));
        i_up      = 1'($urandom_range(0, 1));
        i_clr     = 1'($urandom_range(0, 1));
        step(3);
        check("rst_seg", {25'd0, a_seg}, 32'h0);
        check("rst_dp", {31'd0, a_dp}, 32'h0);
        check("rst_enb", {26'd0, a_enb}, 32'h3F);
        check("rst_tick", {31'd0, a_tick}, 32'h0);
        check("rst_wrap", {31'd0, a_wrap}, 32'h0);

        i_en = 1'b0; i_clr = 1'b0; i_up = 1'b1; i_nco_num = 32'd5;
        rst_n = 1'b1;
        step(1);
        check("first_enb", {26'd0, a_enb}, 32'h3E);
        check("first_seg", {25'd0, a_seg}, 32'h3F);
        check("first_enb2", {30'd0, b_enb}, 32'h2);
        check("first_dp2", {31'd0, b_dp}, 32'h0);

        i_en = 1'b1;
        wait_tick(n); check("nco5_first", n, 5);
        wait_tick(n); check("nco5_period", n, 5);
        i_nco_num = 32'd1;
        wait_tick(n); check("nco1_a", n, 1);
        wait_tick(n); check("nco1_b", n, 1);
        i_nco_num = 32'd0;
        wait_tick(n); check("nco0_a", n, 1);
        wait_tick(n); check("nco0_b", n, 1);

        // 100 ticks from zero: 2-digit instance wraps exactly on the 100th
        i_clr = 1'b1; step(1); i_clr = 1'b0;
        i_up = 1'b1; i_nco_num = 32'd1;
        ticks = 0; bticks = 0; wraps = 0; wrap_at = 0;
        for (int t = 1; t <= 100; t++) begin
            step(1);
            if (a_tick) ticks++;
            if (b_tick) bticks++;
            if (b_wrap) begin wraps++; wrap_at = t; end
        end
        i_en = 1'b0;
        check("up_ticks", ticks, 100);
        check("up_ticks2", bticks, 100);
        check("up_wraps", wraps, 1);
        check("up_wrap_at", wrap_at, 100);
        read_val(1'b1, v); check("up_val2", {8'd0, v}, 32'h000000);
        read_val(1'b0, v); check("up_val6", {8'd0, v}, 32'h000100);

        i_clr = 1'b1; step(1); i_clr = 1'b0;
        i_up = 1'b0; i_en = 1'b1;
        step(1);
        i_en = 1'b0;
        check("down_tick", {31'd0, a_tick}, 32'h1);
        check("down_wrap", {31'd0, a_wrap}, 32'h1);
        read_val(1'b0, v); check("down_val", {8'd0, v}, 32'h999999);
        errs = 0; dp_hi = 0;
        for (int c = 0; c < 6 * SD; c++) begin
            step(1);
            if (a_dp) dp_hi++;
            if (a_dp != (a_enb[0] == 1'b0)) errs++;
        end
        check("dp_align", errs, 0);
        check("dp_cycles", dp_hi, SD);

        // clear beats a tick that would otherwise wrap 999999 -> 000000
        i_up = 1'b1; i_en = 1'b1; i_clr = 1'b1;
        step(1);
        check("clr_tick", {31'd0, a_tick}, 32'h0);
        check("clr_wrap", {31'd0, a_wrap}, 32'h0);
        i_clr = 1'b0; i_en = 1'b0;
        read_val(1'b0, v); check("clr_val", {8'd0, v}, 32'h000000);

        i_clr = 1'b1; step(1); i_clr = 1'b0;
        i_nco_num = 32'd10; i_en = 1'b1;
        wait_tick(n); check("nco10_first", n, 10);
        step(4);
        i_en = 1'b0;
        ticks = 0;
        for (int c = 0; c < 7; c++) begin
            step(1);
            if (a_tick) ticks++;
        end
        check("pause_no_tick", ticks, 0);
        i_en = 1'b1;
        wait_tick(n); check("pause_resume", n, 6);
        i_en = 1'b0;

        i_clr = 1'b1; step(1); i_clr = 1'b0;
        i_up = 1'b1; i_nco_num = 32'd1; i_en = 1'b1;
        step(42);
        i_en = 1'b0;
        read_val(1'b0, v); check("val42", {8'd0, v}, 32'h000042);

        prev = a_enb; n = 0;
        do begin step(1); n++; end while (a_enb == prev && n < 16);
        check("scan_sync", {31'd0, (a_enb != prev)}, 32'h1);
        p0 = 0;
        for (int p = 0; p < 6; p++) if (a_enb == ~(6'd1 << p)) p0 = p;
        errs = 0;
        for (int j = 0; j < 12; j++) begin
            pos = (p0 + j) % 6;
            for (int c = 0; c < SD; c++) begin
                if (!(j == 0 && c == 0)) step(1);
                if (a_enb != ~(6'd1 << pos)) errs++;
                if (c == 0 && j < 6) begin
                    if (pos == 0) exp_seg = 7'h5B;
                    else if (pos == 1) exp_seg = 7'h66;
`ifdef NCO_BCD_CNT_DISP_LZB_EN
                    else exp_seg = 7'h00;
`else
                    else exp_seg = 7'h3F;
`endif
                    check($sformatf("seg_pos%0d", pos), {25'd0, a_seg}, {25'd0, exp_seg});
                end
            end
        end
        check("scan_order", errs, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
